// File: rtl/bola_inimiga.sv
// Enemy-ball controller: spawns, descends once per movement tick, collides with ship/allied ball; outputs registered, 1 cycle after tick.
// Optional ACELERACAO_EN: fall speed grows with score (VEL_INICIAL + pontos/8, max 4 px/tick).
module bola_inimiga #(
    parameter int TICK_DIV       = 500000,
    parameter int RAIO           = 5,
    parameter int Y_LIMITE       = 479,
    parameter int ESPERA_TICKS   = 50,
    parameter int EXPLOSAO_TICKS = 20,
    parameter int VEL_INICIAL    = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] altura_nave,
    input  logic [9:0] x_bola_aliada,
    input  logic [9:0] y_bola_aliada,
    input  logic [9:0] raio_bola_aliada,
    input  logic       aliada_ativa,
    output logic [9:0] x_bola_inimiga,
    output logic [9:0] y_bola_inimiga,
    output logic [9:0] raio_bola_inimiga,
    output logic       ativa,
    output logic       perdeu,
    output logic [7:0] pontos
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_FIM  = TW'(TICK_DIV - 1);
    localparam logic [7:0]    ESP_FIM   = 8'(ESPERA_TICKS - 1);
    localparam logic [7:0]    EXP_FIM   = 8'(EXPLOSAO_TICKS - 1);
    localparam logic [10:0]   R11       = 11'(RAIO);
    localparam logic [10:0]   YLIM11    = 11'(Y_LIMITE);
    localparam logic [2:0]    VEL0      = 3'(VEL_INICIAL);

    typedef enum logic [1:0] {ESPERA, DESCENDO, ATINGIDA, PERDEU} estado_t;

    estado_t       r_estado, w_nxt_estado;
    logic [7:0]    r_espera, w_nxt_espera;
    logic [TW-1:0] r_tick_cnt;
    logic [9:0]    r_lfsr;
    logic [9:0]    r_x, r_y, r_raio, w_nxt_x, w_nxt_y, w_nxt_raio;
    logic          r_ativa, r_perdeu, w_nxt_ativa, w_nxt_perdeu;
    logic [7:0]    r_pontos, w_nxt_pontos, w_pontos_inc;
    logic [2:0]    w_vel;
    logic          w_tick, w_hit_nave, w_hit_aliada;
    logic [10:0]   w_xb, w_yb, w_y_soma;

    // Free-running tick divider; frozen together with everything else under pausa.
    assign w_tick = !pausa && (r_tick_cnt == TICK_FIM);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (reiniciarJogo) begin
            r_tick_cnt <= '0;
        end else if (!pausa) begin
            r_tick_cnt <= (r_tick_cnt == TICK_FIM) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Fibonacci LFSR, taps 10 and 7; deliberately not cleared by a game restart.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 10'h2A5;
        end else if (!pausa) begin
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

    assign w_xb         = {1'b0, r_x};
    assign w_yb         = {1'b0, r_y};
    assign w_y_soma     = w_yb + {8'b0, w_vel};
    assign w_pontos_inc = (r_pontos == 8'hFF) ? 8'hFF : r_pontos + 8'd1;

    assign w_hit_nave = (w_xb + R11 >= {1'b0, x_nave})
                     && (w_xb <= {1'b0, x_nave} + {1'b0, largura_nave} + R11)
                     && (w_yb + R11 >= {1'b0, y_nave})
                     && (w_yb <= {1'b0, y_nave} + {1'b0, altura_nave} + R11);

    assign w_hit_aliada = aliada_ativa
                     && (w_xb + R11 + {1'b0, raio_bola_aliada} >= {1'b0, x_bola_aliada})
                     && ({1'b0, x_bola_aliada} + R11 + {1'b0, raio_bola_aliada} >= w_xb)
                     && (w_yb + R11 + {1'b0, raio_bola_aliada} >= {1'b0, y_bola_aliada})
                     && ({1'b0, y_bola_aliada} + R11 + {1'b0, raio_bola_aliada} >= w_yb);

`ifdef ACELERACAO_EN
    logic [2:0] r_vel, w_nxt_vel, w_vel_calc;
    logic [8:0] w_vel_soma;
    assign w_vel      = r_vel;
    assign w_vel_soma = 9'(VEL_INICIAL) + {4'b0, w_pontos_inc[7:3]};
    assign w_vel_calc = (w_vel_soma > 9'd4) ? 3'd4 : w_vel_soma[2:0];
`else
    assign w_vel = VEL0;
`endif

    always_comb begin
        w_nxt_estado = r_estado;
        w_nxt_espera = r_espera;
        w_nxt_x      = r_x;
        w_nxt_y      = r_y;
        w_nxt_raio   = r_raio;
        w_nxt_ativa  = r_ativa;
        w_nxt_perdeu = r_perdeu;
        w_nxt_pontos = r_pontos;
`ifdef ACELERACAO_EN
        w_nxt_vel    = r_vel;
`endif
        case (r_estado)
            ESPERA: begin
                w_nxt_raio  = '0;
                w_nxt_ativa = 1'b0;
                if (r_espera == ESP_FIM) begin
                    w_nxt_x      = {1'b0, r_lfsr[8:0]} + 10'd64;
                    w_nxt_y      = 10'(RAIO);
                    w_nxt_raio   = 10'(RAIO);
                    w_nxt_ativa  = 1'b1;
                    w_nxt_espera = '0;
                    w_nxt_estado = DESCENDO;
                end else begin
                    w_nxt_espera = r_espera + 8'd1;
                end
            end
            DESCENDO: begin
                if (w_hit_nave) begin
                    w_nxt_perdeu = 1'b1;
                    w_nxt_estado = PERDEU;
                end else if (w_hit_aliada) begin
                    w_nxt_pontos = w_pontos_inc;
                    w_nxt_raio   = 10'(2 * RAIO);
                    w_nxt_ativa  = 1'b0;
                    w_nxt_espera = '0;
                    w_nxt_estado = ATINGIDA;
`ifdef ACELERACAO_EN
                    w_nxt_vel    = w_vel_calc;
`endif
                end else if (w_y_soma >= YLIM11) begin
                    w_nxt_raio   = '0;
                    w_nxt_ativa  = 1'b0;
                    w_nxt_espera = '0;
                    w_nxt_estado = ESPERA;
                end else begin
                    w_nxt_y = w_y_soma[9:0];
                end
            end
            ATINGIDA: begin
                if (r_espera == EXP_FIM) begin
                    w_nxt_raio   = '0;
                    w_nxt_espera = '0;
                    w_nxt_estado = ESPERA;
                end else begin
                    w_nxt_espera = r_espera + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset || reiniciarJogo) begin
            r_estado <= ESPERA;
            r_espera <= '0;
            r_x      <= 10'd320;
            r_y      <= '0;
            r_raio   <= '0;
            r_ativa  <= 1'b0;
            r_perdeu <= 1'b0;
            r_pontos <= '0;
`ifdef ACELERACAO_EN
            r_vel    <= VEL0;
`endif
        end else if (w_tick) begin
            r_estado <= w_nxt_estado;
            r_espera <= w_nxt_espera;
            r_x      <= w_nxt_x;
            r_y      <= w_nxt_y;
            r_raio   <= w_nxt_raio;
            r_ativa  <= w_nxt_ativa;
            r_perdeu <= w_nxt_perdeu;
            r_pontos <= w_nxt_pontos;
`ifdef ACELERACAO_EN
            r_vel    <= w_nxt_vel;
`endif
        end
    end

    assign x_bola_inimiga    = r_x;
    assign y_bola_inimiga    = r_y;
    assign raio_bola_inimiga = r_raio;
    assign ativa             = r_ativa;
    assign perdeu            = r_perdeu;
    assign pontos            = r_pontos;
endmodule

// File: tb/tb_bola_inimiga.sv
// Directed bench for bola_inimiga with TICK_DIV=4, ESPERA_TICKS=2, EXPLOSAO_TICKS=2.
module tb_bola_inimiga;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       pausa = 1'b0;
    logic       reiniciarJogo = 1'b0;
    logic [9:0] x_nave = 10'd0, y_nave = 10'd400, largura_nave = 10'd10, altura_nave = 10'd10;
    logic [9:0] x_bola_aliada = 10'd0, y_bola_aliada = 10'd0, raio_bola_aliada = 10'd3;
    logic       aliada_ativa = 1'b0;
    logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic       ativa, perdeu;
    logic [7:0] pontos;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] x_reg;

    always #5 CLOCK_50 = ~CLOCK_50;

    bola_inimiga #(
        .TICK_DIV(4), .RAIO(5), .Y_LIMITE(479),
        .ESPERA_TICKS(2), .EXPLOSAO_TICKS(2), .VEL_INICIAL(1)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
        .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave), .altura_nave(altura_nave),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
        .raio_bola_aliada(raio_bola_aliada), .aliada_ativa(aliada_ativa),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
        .raio_bola_inimiga(raio_bola_inimiga), .ativa(ativa), .perdeu(perdeu), .pontos(pontos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        clocks(4 * n);
    endtask

    // Hit a freshly spawned ball with the allied ball, then wait for the next spawn.
    task automatic do_hit();
        x_bola_aliada = x_bola_inimiga;
        y_bola_aliada = y_bola_inimiga;
        aliada_ativa  = 1'b1;
        ticks(1);
        aliada_ativa  = 1'b0;
        ticks(4);
    endtask

    initial begin
        #22;
        check("rst_x", x_bola_inimiga, 320);
        check("rst_y", y_bola_inimiga, 0);
        check("rst_raio", raio_bola_inimiga, 0);
        check("rst_ativa", ativa, 0);
        check("rst_perdeu", perdeu, 0);
        check("rst_pontos", pontos, 0);
        @(negedge CLOCK_50);
        reset = 1'b1;

        ticks(1);
        check("wait1_ativa", ativa, 0);
        ticks(1);
        check("spawn_ativa", ativa, 1);
        check("spawn_y", y_bola_inimiga, 5);
        check("spawn_raio", raio_bola_inimiga, 5);
        check("spawn_x_range", (x_bola_inimiga >= 10'd64) && (x_bola_inimiga <= 10'd575), 1);
        ticks(1);
        check("move_y6", y_bola_inimiga, 6);
        clocks(2);
        check("between_ticks_y", y_bola_inimiga, 6);
        clocks(2);
        check("move_y7", y_bola_inimiga, 7);

        ticks(471);
        check("bottom_y478", y_bola_inimiga, 478);
        ticks(1);
        check("despawn_ativa", ativa, 0);
        check("despawn_raio", raio_bola_inimiga, 0);
        check("despawn_pontos", pontos, 0);
        ticks(1);
        check("respawn_wait", ativa, 0);
        ticks(1);
        check("respawn_ativa", ativa, 1);
        check("respawn_y", y_bola_inimiga, 5);

        // Allied ball present only between ticks: must be ignored.
        x_reg = x_bola_inimiga;
        x_bola_aliada = x_reg; y_bola_aliada = 10'd5; aliada_ativa = 1'b1;
        clocks(1);
        aliada_ativa = 1'b0;
        clocks(3);
        check("glitch_pontos", pontos, 0);
        check("glitch_y", y_bola_inimiga, 6);

        x_bola_aliada = x_reg; y_bola_aliada = 10'd6; aliada_ativa = 1'b1;
        ticks(1);
        aliada_ativa = 1'b0;
        check("hit_pontos", pontos, 1);
        check("hit_raio", raio_bola_inimiga, 10);
        check("hit_ativa", ativa, 0);
        ticks(1);
        check("expl_raio", raio_bola_inimiga, 10);
        ticks(1);
        check("expl_end_raio", raio_bola_inimiga, 0);
        ticks(2);
        check("hit_respawn", ativa, 1);

        pausa = 1'b1;
        clocks(40);
        check("pausa_y", y_bola_inimiga, 5);
        pausa = 1'b0;
        ticks(1);
        check("after_pausa_y", y_bola_inimiga, 6);

        x_reg = x_bola_inimiga;
        x_nave = x_reg; y_nave = 10'd0;
        x_bola_aliada = x_reg; y_bola_aliada = 10'd6; aliada_ativa = 1'b1;
        ticks(1);
        check("simul_perdeu", perdeu, 1);
        check("simul_pontos", pontos, 1);
        check("simul_raio", raio_bola_inimiga, 5);
        ticks(100);
        check("frozen_perdeu", perdeu, 1);
        check("frozen_pontos", pontos, 1);
        check("frozen_y", y_bola_inimiga, 6);
        check("frozen_raio", raio_bola_inimiga, 5);

        pausa = 1'b1; reiniciarJogo = 1'b1;
        clocks(1);
        check("restart_perdeu", perdeu, 0);
        check("restart_pontos", pontos, 0);
        check("restart_raio", raio_bola_inimiga, 0);
        check("restart_x", x_bola_inimiga, 320);
        check("restart_y", y_bola_inimiga, 0);
        reiniciarJogo = 1'b0; pausa = 1'b0; aliada_ativa = 1'b0;
        x_nave = 10'd0; y_nave = 10'd400;

        ticks(2);
        check("restart_spawn", ativa, 1);
        ticks(1);
        check("restart_move", y_bola_inimiga, 6);
        #3 reset = 1'b0;
        #1;
        check("arst_ativa", ativa, 0);
        check("arst_y", y_bola_inimiga, 0);
        check("arst_x", x_bola_inimiga, 320);
        #2 reset = 1'b1;
        ticks(2);
        check("arst_respawn_y", y_bola_inimiga, 5);

`ifdef ACELERACAO_EN
        for (int i = 0; i < 8; i++) do_hit();
        check("acc_pontos8", pontos, 8);
        ticks(1);
        check("acc_vel2", y_bola_inimiga, 7);
        for (int i = 0; i < 247; i++) do_hit();
        check("acc_pontos255", pontos, 255);
        do_hit();
        check("acc_sat", pontos, 255);
        ticks(1);
        check("acc_vel4", y_bola_inimiga, 9);
`else
        do_hit();
        check("base_pontos", pontos, 1);
        ticks(1);
        check("base_vel1", y_bola_inimiga, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bola_inimiga.md
Name: bola_inimiga

Overview:
- Enemy-ball controller; replaces the constant enemy-ball coordinates at the game top level.
- Spawns an enemy ball at a pseudo-random column, moves it down the 640x480 field, and tests it each movement tick against the ship rectangle and the allied ball.
- Drives x/y/raio of the enemy ball into the frame-memory/renderer block, plus perdeu (game over) and a score counter.

Parameters:
- TICK_DIV, 500000: CLOCK_50 cycles per movement tick (100 Hz).
- RAIO, 5: enemy ball radius in pixels.
- Y_LIMITE, 479: bottom row; reaching it despawns the ball without scoring.
- ESPERA_TICKS, 50: ticks between despawn/hit and the next spawn.
- EXPLOSAO_TICKS, 20: ticks the explosion is shown after a hit.
- VEL_INICIAL, 1: pixels moved per tick.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pausa  in  1  1 = freeze all state, including the tick counter.
- reiniciarJogo  in  1  synchronous game restart; priority over pausa.
- x_nave, y_nave  in  10 each  ship top-left corner.
- largura_nave, altura_nave  in  10 each  ship size.
- x_bola_aliada, y_bola_aliada, raio_bola_aliada  in  10 each  allied ball center and radius.
- aliada_ativa  in  1  1 = allied ball in flight, eligible for collision.
- x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga  out  10 each  enemy ball center and radius; raio 0 = not drawn.
- ativa  out  1  enemy ball in flight.
- perdeu  out  1  game-over flag.
- pontos  out  8  hits scored, saturating.

Behaviour:
- Reset values:
  - x=320, y=0, raio=0, ativa=0, perdeu=0, pontos=0.
  - State ESPERA, wait counter 0, tick counter 0, LFSR=10'h2A5, velocidade=VEL_INICIAL.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps; a one-cycle tick pulses when count==TICK_DIV-1.
  - Held while pausa=1.
  - LFSR (10-bit, taps 10,7) advances every unpaused clock.
- All outputs are registered and change the cycle after the tick. Nothing changes between ticks except the tick counter and LFSR.
- Arithmetic: 11-bit unsigned, no subtraction.
  - Ship hit: xb+r >= xn, xb <= xn+l+r, yb+r >= yn, yb <= yn+h+r, where r=RAIO.
  - Allied hit (only when aliada_ativa=1): xb+RAIO+ra >= xa, xa+RAIO+ra >= xb, same two tests in y.
- FSM, evaluated on tick:
  - ESPERA:
    - raio=0, ativa=0; wait counter increments.
    - At ESPERA_TICKS-1: x = LFSR[8:0]+64 (range 64..575), y=RAIO, raio=RAIO, ativa=1, wait counter cleared -> DESCENDO.
  - DESCENDO, checks in priority order:
    1. Ship hit -> PERDEU; perdeu=1; ball frozen and still drawn.
    2. Else allied hit -> ATINGIDA; pontos+1, saturating at 255; raio=2*RAIO; ativa=0.
    3. Else y+vel >= Y_LIMITE -> ESPERA; raio=0, ativa=0; no point.
    4. Else y += vel.
  - ATINGIDA: after EXPLOSAO_TICKS ticks -> ESPERA with raio=0.
  - PERDEU: terminal; ignores ticks and holds all outputs.
- reiniciarJogo=1 on any clock:
  - Next cycle: every register returns to its reset value except the LFSR, which keeps running.
  - Takes priority over pausa and over a same-cycle tick.
- Simultaneous ship hit and allied hit on one tick: ship wins, perdeu=1, pontos unchanged.
- Asynchronous reset asserted mid-flight: outputs go to reset values immediately, not at the next clock edge.
- Collision inputs are sampled only on tick cycles; a glitch between ticks has no effect.

Optional Feature:
- Macro: ACELERACAO_EN.
- Defined:
  - velocidade = VEL_INICIAL + (pontos >> 3), capped at 4.
  - Updated on the same tick as the scoring hit; applies from the next spawn.
  - Restored to VEL_INICIAL by reset or reiniciarJogo.
- Undefined: velocidade is constant VEL_INICIAL; no extra logic.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, ESPERA_TICKS=2, EXPLOSAO_TICKS=2.
- Reset, then release with ship far away (xn=0, yn=400) -> after 2 ticks: ativa=1, y=5, raio=5, x in 64..575; y +1 per tick (every 4 clocks).
- Ball reaches Y_LIMITE: y=478 with vel=1 -> next tick ativa=0, raio=0, pontos stays 0; respawn 2 ticks later.
- Allied hit: aliada_ativa=1, allied ball at the enemy center, ra=3 -> pontos 0->1, raio=10 for 2 ticks, then raio=0 (ESPERA).
- Simultaneous hit: ship rectangle and allied ball overlap the enemy on the same tick -> perdeu=1, pontos unchanged; outputs frozen 100 ticks later.
- Control and reset: pausa=1 for 40 clocks mid-flight -> y unchanged. Then assert pausa=1 and reiniciarJogo=1 together -> next cycle perdeu=0, pontos=0, raio=0. Async reset between clock edges -> outputs reset immediately.
- ACELERACAO_EN defined: 8 consecutive allied hits -> pontos=8, next spawn moves 2 px/tick. pontos=255 plus one hit -> stays 255, velocity capped at 4.
